// File: rtl/rv32i_pkg.sv
// RV32I decode definitions: opcodes, immediate formats, DE payload and immediate generator.
package rv32i_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned OPC_W = 7;

    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;

    typedef struct packed {
        logic             valid;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  rs1_val;
        logic [XLEN-1:0]  rs2_val;
        logic [XLEN-1:0]  imm;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic [OPC_W-1:0] opcode;
        logic [2:0]       funct3;
        logic             funct7b5;
        logic             reg_we;
        logic             mem_rd;
        logic             mem_wr;
        logic             illegal;
    } de_t;

    // All formats sign-extend from instr[31].
    function automatic logic [XLEN-1:0] gen_imm(input logic [XLEN-1:0] instr, input imm_type_e sel);
        logic [XLEN-1:0] imm;
        case (sel)
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = {{20{instr[31]}}, instr[31:20]};
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/regfile.sv
// 32x32 architectural register file: two async read ports with write-first bypass, one sync write port.
module regfile
    import rv32i_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic [REG_W-1:0] ra1,
    input  logic [REG_W-1:0] ra2,
    output logic [XLEN-1:0]  rdata1_c,
    output logic [XLEN-1:0]  rdata2_c,
    input  logic             we,
    input  logic [REG_W-1:0] wa,
    input  logic [XLEN-1:0]  wdata
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic            wr_en;

    assign wr_en = we && (wa != '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[wa] = wdata;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // x0 reads zero; a same-cycle write to the read index is forwarded.
    always_comb begin
        rdata1_c = '0;
        if (ra1 != '0) begin
            rdata1_c = (wr_en && (wa == ra1)) ? wdata : regs_q[ra1];
        end
    end

    always_comb begin
        rdata2_c = '0;
        if (ra2 != '0) begin
            rdata2_c = (wr_en && (wa == ra2)) ? wdata : regs_q[ra2];
        end
    end

endmodule

// File: rtl/d_stage.sv
// RV32I decode stage: decode, register read, immediate generation, load-use stall, DE register.
module d_stage
    import rv32i_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic [XLEN-1:0]  fd_pc,
    input  logic [XLEN-1:0]  fd_instr,
    input  logic             e_ready,
    input  logic             flush,
    input  logic             wb_en,
    input  logic [REG_W-1:0] wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    output logic             d_ready,
    output logic             de_valid,
    output logic [XLEN-1:0]  de_pc,
    output logic [XLEN-1:0]  de_rs1_val,
    output logic [XLEN-1:0]  de_rs2_val,
    output logic [XLEN-1:0]  de_imm,
    output logic [REG_W-1:0] de_rs1,
    output logic [REG_W-1:0] de_rs2,
    output logic [REG_W-1:0] de_rd,
    output logic [OPC_W-1:0] de_opcode,
    output logic [2:0]       de_funct3,
    output logic             de_funct7b5,
    output logic             de_reg_we,
    output logic             de_mem_rd,
    output logic             de_mem_wr,
    output logic             de_illegal
);

    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] rs1, rs2, rd;
    logic             illegal, uses_rs1, uses_rs2, writes_rd, mem_rd, mem_wr;
    imm_type_e        imm_sel;
    logic [XLEN-1:0]  rs1_val, rs2_val;
    logic             load_use;
    de_t              dec, de_d, de_q;

    assign opcode = fd_instr[6:0];
    assign rd     = fd_instr[11:7];
    assign rs1    = fd_instr[19:15];
    assign rs2    = fd_instr[24:20];

    regfile u_regfile (
        .clock    (clock),
        .reset    (reset),
        .ra1      (rs1),
        .ra2      (rs2),
        .rdata1_c (rs1_val),
        .rdata2_c (rs2_val),
        .we       (wb_en),
        .wa       (wb_rd),
        .wdata    (wb_data)
    );

    // Opcode class decode.
    always_comb begin
        illegal   = 1'b0;
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        writes_rd = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        imm_sel   = IMM_I;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin writes_rd = 1'b1; imm_sel = IMM_U; end
            OPC_JAL:            begin writes_rd = 1'b1; imm_sel = IMM_J; end
            OPC_JALR:           begin writes_rd = 1'b1; uses_rs1 = 1'b1; end
            OPC_BRANCH:         begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; imm_sel = IMM_B; end
            OPC_LOAD:           begin writes_rd = 1'b1; uses_rs1 = 1'b1; mem_rd = 1'b1; end
            OPC_STORE:          begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; mem_wr = 1'b1; imm_sel = IMM_S; end
            OPC_OPIMM:          begin writes_rd = 1'b1; uses_rs1 = 1'b1; end
            OPC_OP:             begin writes_rd = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            default:            illegal = 1'b1;
        endcase
    end

    always_comb begin
        dec          = '0;
        dec.valid    = !illegal;
        dec.pc       = fd_pc;
        dec.rs1_val  = rs1_val;
        dec.rs2_val  = rs2_val;
        dec.imm      = gen_imm(fd_instr, imm_sel);
        dec.rs1      = rs1;
        dec.rs2      = rs2;
        dec.rd       = rd;
        dec.opcode   = opcode;
        dec.funct3   = fd_instr[14:12];
        dec.funct7b5 = fd_instr[30];
        dec.reg_we   = writes_rd && (rd != '0);
        dec.mem_rd   = mem_rd;
        dec.mem_wr   = mem_wr;
        dec.illegal  = illegal;
    end

    assign load_use = de_q.valid && de_q.mem_rd && (de_q.rd != '0) &&
                      ((uses_rs1 && (rs1 == de_q.rd)) || (uses_rs2 && (rs2 == de_q.rd)));

    // A flush must pass even during a stall so fetch's redirect is not dropped.
    assign d_ready = e_ready && (!load_use || flush);

    always_comb begin
        de_d = de_q;
        if (flush || (e_ready && load_use)) begin
            de_d         = dec;
            de_d.valid   = 1'b0;
            de_d.reg_we  = 1'b0;
            de_d.mem_rd  = 1'b0;
            de_d.mem_wr  = 1'b0;
            de_d.illegal = 1'b0;
        end else if (e_ready) begin
            de_d = dec;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            de_q <= '0;
        end else begin
            de_q <= de_d;
        end
    end

    assign de_valid    = de_q.valid;
    assign de_pc       = de_q.pc;
    assign de_rs1_val  = de_q.rs1_val;
    assign de_rs2_val  = de_q.rs2_val;
    assign de_imm      = de_q.imm;
    assign de_rs1      = de_q.rs1;
    assign de_rs2      = de_q.rs2;
    assign de_rd       = de_q.rd;
    assign de_opcode   = de_q.opcode;
    assign de_funct3   = de_q.funct3;
    assign de_funct7b5 = de_q.funct7b5;
    assign de_reg_we   = de_q.reg_we;
    assign de_mem_rd   = de_q.mem_rd;
    assign de_mem_wr   = de_q.mem_wr;
    assign de_illegal  = de_q.illegal;

endmodule
